alu_sched: RTL and testbench

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_sched_pkg.sv | 20 ++
 rtl/alu_sched_alu_core.sv | 32 +++
 rtl/alu_sched.sv | 127 ++++++++++++
 tb/tb_alu_sched.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// alu_sched shared definitions: ALU opcodes and scheduler FSM encoding.
// Optional build macro for the whole slice: ALU_SCHED_STATS_EN.
package alu_sched_pkg;

  localparam logic [2:0] OP_ZERO = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_ONES = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_sched_alu_core.sv
// alu_core: purely combinational ALU, decoded from the low three opcode bits.
// Add/sub wrap modulo 2^DATA_W.
module alu_core
  import alu_sched_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [SEL_W-1:0]  Sel,
  output logic [DATA_W-1:0] y
);

  logic [2:0] op;
  assign op = Sel[2:0];

  always_comb begin
    y = '0;
    unique case (op)
      OP_ZERO: y = '0;
      OP_AND:  y = A & B;
      OP_OR:   y = A | B;
      OP_XOR:  y = A ^ B;
      OP_ADD:  y = A + B;
      OP_SUB:  y = A - B;
      OP_NOT:  y = ~A;
      OP_ONES: y = '1;
    endcase
  end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: two-requester round-robin front end to a shared registered ALU.
// Define ALU_SCHED_STATS_EN to add per-requester grant counters.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld0,
  input  logic              req_vld1,
  output logic              req_rdy0,
  output logic              req_rdy1,
  input  logic [DATA_W-1:0] A0,
  input  logic [DATA_W-1:0] B0,
  input  logic [DATA_W-1:0] A1,
  input  logic [DATA_W-1:0] B1,
  input  logic [SEL_W-1:0]  Sel0,
  input  logic [SEL_W-1:0]  Sel1,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_y
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [7:0]        gnt_cnt0,
  output logic [7:0]        gnt_cnt1
`endif
);

  state_t state, nxt;

  logic              prio;
  logic [DATA_W-1:0] cap_a, cap_b;
  logic [SEL_W-1:0]  cap_sel;
  logic              cap_id;
  logic [DATA_W-1:0] alu_y;
  logic              xfer0, xfer1, done;

  alu_core #(
    .DATA_W(DATA_W),
    .SEL_W (SEL_W)
  ) u_alu (
    .A  (cap_a),
    .B  (cap_b),
    .Sel(cap_sel),
    .y  (alu_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Grants are masked during reset so no request looks accepted.
  always_comb begin
    nxt      = state;
    req_rdy0 = 1'b0;
    req_rdy1 = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        req_rdy0 = !rst && req_vld0 && (!prio || !req_vld1);
        req_rdy1 = !rst && req_vld1 && (prio || !req_vld0);
        if (req_rdy0 || req_rdy1) nxt = EXEC;
      end
      EXEC: nxt = HOLD;
      HOLD: begin
        done = rsp_vld && rsp_rdy;
        if (done) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign xfer0 = req_vld0 && req_rdy0;
  assign xfer1 = req_vld1 && req_rdy1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio    <= 1'b0;
      cap_a   <= '0;
      cap_b   <= '0;
      cap_sel <= '0;
      cap_id  <= 1'b0;
      rsp_vld <= 1'b0;
      rsp_y   <= '0;
      rsp_id  <= 1'b0;
    end else begin
      if (xfer0) begin
        cap_a   <= A0;
        cap_b   <= B0;
        cap_sel <= Sel0;
        cap_id  <= 1'b0;
      end else if (xfer1) begin
        cap_a   <= A1;
        cap_b   <= B1;
        cap_sel <= Sel1;
        cap_id  <= 1'b1;
      end
      if (state == EXEC) begin
        rsp_y   <= alu_y;
        rsp_id  <= cap_id;
        rsp_vld <= 1'b1;
      end
      // Loser of the next contention is whoever was just served.
      if (done) begin
        rsp_vld <= 1'b0;
        prio    <= !rsp_id;
      end
    end
  end

`ifdef ALU_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0 <= 8'd0;
      gnt_cnt1 <= 8'd0;
    end else begin
      if (xfer0) gnt_cnt0 <= gnt_cnt0 + 8'd1;
      if (xfer1) gnt_cnt1 <= gnt_cnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched; stats checks compile in with ALU_SCHED_STATS_EN.
module tb_alu_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_vld0, req_vld1;
  logic       req_rdy0, req_rdy1;
  logic [7:0] A0, B0, A1, B1;
  logic [2:0] Sel0, Sel1;
  logic       rsp_vld, rsp_rdy, rsp_id;
  logic [7:0] rsp_y;
`ifdef ALU_SCHED_STATS_EN
  logic [7:0] gnt_cnt0, gnt_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sched dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld0(req_vld0),
    .req_vld1(req_vld1),
    .req_rdy0(req_rdy0),
    .req_rdy1(req_rdy1),
    .A0      (A0),
    .B0      (B0),
    .A1      (A1),
    .B1      (B1),
    .Sel0    (Sel0),
    .Sel1    (Sel1),
    .rsp_vld (rsp_vld),
    .rsp_rdy (rsp_rdy),
    .rsp_id  (rsp_id),
    .rsp_y   (rsp_y)
`ifdef ALU_SCHED_STATS_EN
    ,
    .gnt_cnt0(gnt_cnt0),
    .gnt_cnt1(gnt_cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Starts at a negedge in IDLE with rsp_rdy=1; ends back in IDLE.
  task automatic do_op(input bit n, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] s, input logic [7:0] ey,
                       input string tag);
    int k;
    if (n) begin
      req_vld1 = 1'b1; A1 = a; B1 = b; Sel1 = s;
    end else begin
      req_vld0 = 1'b1; A0 = a; B0 = b; Sel0 = s;
    end
    #1;
    k = 0;
    while (!(n ? req_rdy1 : req_rdy0) && k < 10) begin
      tick();
      k++;
    end
    chk({tag, "_gnt"}, {31'd0, n ? req_rdy1 : req_rdy0}, 32'd1);
    tick();
    if (n) req_vld1 = 1'b0;
    else   req_vld0 = 1'b0;
    chk({tag, "_lat1"}, {31'd0, rsp_vld}, 32'd0);
    tick();
    chk({tag, "_vld"}, {31'd0, rsp_vld}, 32'd1);
    chk({tag, "_y"}, {24'd0, rsp_y}, {24'd0, ey});
    chk({tag, "_id"}, {31'd0, rsp_id}, {31'd0, n});
    tick();
    chk({tag, "_clr"}, {31'd0, rsp_vld}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_vld0 = 1'b1; req_vld1 = 1'b1;
    A0 = 8'h00; B0 = 8'h31; Sel0 = 3'b001;
    A1 = 8'h00; B1 = 8'h00; Sel1 = 3'b000;
    rsp_rdy = 1'b1;

    tick();
    chk("rst_vld", {31'd0, rsp_vld}, 32'd0);
    chk("rst_y", {24'd0, rsp_y}, 32'd0);
    chk("rst_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_rdy0", {31'd0, req_rdy0}, 32'd0);
    chk("rst_rdy1", {31'd0, req_rdy1}, 32'd0);
    req_vld0 = 1'b0; req_vld1 = 1'b0;
    rst = 1'b0;

    do_op(1'b0, 8'h00, 8'h31, 3'b001, 8'h00, "and");
    do_op(1'b1, 8'hFF, 8'h02, 3'b100, 8'h01, "add_wrap");
    do_op(1'b1, 8'h00, 8'h01, 3'b101, 8'hFF, "sub_wrap");
    do_op(1'b0, 8'hA5, 8'h0F, 3'b011, 8'hAA, "xor");
    do_op(1'b1, 8'h3C, 8'h00, 3'b110, 8'hC3, "not");
    do_op(1'b0, 8'h12, 8'h40, 3'b010, 8'h52, "or");
    do_op(1'b1, 8'h77, 8'h77, 3'b000, 8'h00, "zero");
    do_op(1'b0, 8'h00, 8'h00, 3'b111, 8'hFF, "ones");

    // Reset while a result is parked in HOLD.
    rsp_rdy = 1'b0;
    req_vld0 = 1'b1; A0 = 8'h5A; B0 = 8'hFF; Sel0 = 3'b001;
    tick();
    req_vld0 = 1'b0;
    tick();
    chk("hold_vld", {31'd0, rsp_vld}, 32'd1);
    chk("hold_y", {24'd0, rsp_y}, 32'h5A);
    rst = 1'b1;
    #1;
    chk("arst_vld", {31'd0, rsp_vld}, 32'd0);
    chk("arst_y", {24'd0, rsp_y}, 32'd0);
    tick();
    rst = 1'b0;
    rsp_rdy = 1'b1;
    tick();
    chk("post_rst_vld_a", {31'd0, rsp_vld}, 32'd0);
    tick();
    chk("post_rst_vld_b", {31'd0, rsp_vld}, 32'd0);

    // Contention: both held, prio=0 after reset.
    req_vld0 = 1'b1; A0 = 8'h10; B0 = 8'h01; Sel0 = 3'b100;
    req_vld1 = 1'b1; A1 = 8'h20; B1 = 8'h01; Sel1 = 3'b101;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("cont%0d_rdy0", i), {31'd0, req_rdy0},
          (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("cont%0d_rdy1", i), {31'd0, req_rdy1},
          (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      tick();
      chk($sformatf("cont%0d_vld", i), {31'd0, rsp_vld}, 32'd1);
      chk($sformatf("cont%0d_id", i), {31'd0, rsp_id},
          (i % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("cont%0d_y", i), {24'd0, rsp_y},
          (i % 2 == 1) ? 32'h1F : 32'h11);
      tick();
    end
    req_vld0 = 1'b0; req_vld1 = 1'b0;

    // Backpressure: last served was 1, so requester 0 wins first.
    rsp_rdy = 1'b0;
    req_vld0 = 1'b1; A0 = 8'hF0; B0 = 8'h0F; Sel0 = 3'b010;
    req_vld1 = 1'b1; A1 = 8'h33; B1 = 8'h0F; Sel1 = 3'b011;
    #1;
    chk("bp_gnt0", {31'd0, req_rdy0}, 32'd1);
    tick();
    req_vld0 = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_vld", i), {31'd0, rsp_vld}, 32'd1);
      chk($sformatf("bp%0d_y", i), {24'd0, rsp_y}, 32'hFF);
      chk($sformatf("bp%0d_id", i), {31'd0, rsp_id}, 32'd0);
      chk($sformatf("bp%0d_rdy", i), {30'd0, req_rdy1, req_rdy0}, 32'd0);
      tick();
    end
    rsp_rdy = 1'b1;
    tick();
    chk("bp_release_vld", {31'd0, rsp_vld}, 32'd0);
    chk("bp_next_gnt1", {31'd0, req_rdy1}, 32'd1);
    tick();
    req_vld1 = 1'b0;
    tick();
    chk("bp_next_id", {31'd0, rsp_id}, 32'd1);
    chk("bp_next_y", {24'd0, rsp_y}, 32'h3C);
    tick();
    chk("bp_next_clr", {31'd0, rsp_vld}, 32'd0);

`ifdef ALU_SCHED_STATS_EN
    rst = 1'b1;
    #1;
    chk("cnt_rst0", {24'd0, gnt_cnt0}, 32'd0);
    chk("cnt_rst1", {24'd0, gnt_cnt1}, 32'd0);
    tick();
    rst = 1'b0;
    do_op(1'b0, 8'h01, 8'h01, 3'b100, 8'h02, "s0");
    do_op(1'b1, 8'h01, 8'h01, 3'b100, 8'h02, "s1");
    do_op(1'b0, 8'h01, 8'h01, 3'b100, 8'h02, "s2");
    do_op(1'b1, 8'h01, 8'h01, 3'b100, 8'h02, "s3");
    do_op(1'b0, 8'h01, 8'h01, 3'b100, 8'h02, "s4");
    chk("cnt0_3", {24'd0, gnt_cnt0}, 32'd3);
    chk("cnt1_2", {24'd0, gnt_cnt1}, 32'd2);
    for (int i = 0; i < 253; i++) begin
      req_vld0 = 1'b1;
      #1;
      if (req_rdy0 !== 1'b1) chk("wrap_gnt", {31'd0, req_rdy0}, 32'd1);
      tick();
      req_vld0 = 1'b0;
      tick();
      tick();
    end
    chk("cnt0_wrap", {24'd0, gnt_cnt0}, 32'd0);
    chk("cnt1_keep", {24'd0, gnt_cnt1}, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
